camera_sequencer: RTL and testbench
===================================

CAMERA_SEQUENCER -- requirements
Module: camera_sequencer

Interface
REQ-001 Parameter IDLE_CYC, default 4: cycles spent in IDLE (counted only while enable=1) before each frame; legal range 1..2^CNT_W.
REQ-002 Parameter PULSE_CNT, default 2: shutter pulses per frame; must be >=1.
REQ-003 Parameter PULSE_GAP, default 3: cycles from one shutter pulse to the next; must be >=2.
REQ-004 Parameter PROC_CYC, default 5: maximum cycles in PROCESS; legal range 1..2^CNT_W.
REQ-005 Parameter CNT_W, default 4: dwell-counter width; 2^CNT_W must be >= max(IDLE_CYC, PULSE_CNT*PULSE_GAP+1, PROC_CYC).
REQ-006 Parameter FRAME_W, default 8: frame counter width.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 enable  input  1  1 = IDLE dwell counts down; 0 = IDLE dwell holds.
REQ-010 skip  input  1  in PROCESS, ends processing early; ignored in other states.
REQ-011 abort  input  1  cancels the current frame from any state.
REQ-012 shutter  output  1  registered shutter strobe.
REQ-013 state  output  2  current state: IDLE=00, EXPOSE=01, PROCESS=10.
REQ-014 frame_done  output  1  registered one-cycle pulse on frame completion.
REQ-015 frame_cnt  output  FRAME_W  count of completed frames; wraps modulo 2^FRAME_W.

Function
REQ-016 The block SHALL implement the FSM IDLE -> EXPOSE -> PROCESS -> IDLE, driven by one down-counter of CNT_W bits that is reloaded on every state entry.
REQ-017 IDLE SHALL load the counter with IDLE_CYC-1 on entry.
- enable=1: counter decrements each cycle; at counter==0 the FSM moves to EXPOSE on the next cycle.
- enable=0: counter and state hold.
REQ-018 EXPOSE SHALL last exactly PULSE_CNT*PULSE_GAP+1 cycles, then move to PROCESS; enable is ignored in EXPOSE.
REQ-019 Numbering the first EXPOSE cycle as 0, shutter SHALL be 1 exactly in EXPOSE cycles 0, PULSE_GAP, ..., (PULSE_CNT-1)*PULSE_GAP, and 0 in every other cycle and every other state. The output is registered: no combinational path from any input to shutter.
REQ-020 PROCESS SHALL last PROC_CYC cycles and then move to IDLE. If skip=1 in any PROCESS cycle, the FSM SHALL be in IDLE on the next cycle. enable is ignored in PROCESS.
REQ-021 On any exit from PROCESS (normal or skip), frame_done SHALL be 1 for exactly the first IDLE cycle, and frame_cnt SHALL increment by 1 in that same cycle, wrapping from all-ones to 0.
REQ-022 abort=1 in any state SHALL cause, on the next cycle:
- state=IDLE, counter=IDLE_CYC-1, shutter=0;
- no frame_done pulse and frame_cnt unchanged.
REQ-023 Priority, highest first: reset > abort > skip > normal dwell; abort and skip together behave as abort.
REQ-024 Unreachable state code 11 SHALL return to IDLE on the next cycle, with the counter reloaded and shutter=0.
REQ-025 With defaults and enable held at 1, the frame period SHALL be 16 cycles (IDLE 4 + EXPOSE 7 + PROCESS 5).

Reset
REQ-026 While reset=1 at a rising clk edge, the next-cycle values SHALL be: state=IDLE, counter=IDLE_CYC-1, shutter=0, frame_done=0, frame_cnt=0.
REQ-027 Reset SHALL take effect from any state, including mid-EXPOSE with shutter high; the first EXPOSE after release SHALL begin IDLE_CYC enabled cycles after release.

Verification
REQ-028 Defaults, reset pulse, then enable=1 -> state 00 for 4 cycles, 01 for 7 cycles with shutter=1 in EXPOSE cycles 0 and 3 only, 10 for 5 cycles, then frame_done=1 for one cycle and frame_cnt=1; the next frame repeats with period 16.
REQ-029 Defaults, skip=1 in PROCESS cycle 1 -> IDLE in the next cycle, frame_done=1, frame_cnt increments, frame period 13.
REQ-030 Defaults, enable=0 for 3 cycles in mid-IDLE -> IDLE lasts 7 cycles; enable=0 during EXPOSE or PROCESS -> no change to timing.
REQ-031 Defaults, abort=1 in EXPOSE cycle 0 (shutter=1) -> next cycle state=00, shutter=0, no frame_done, frame_cnt unchanged; abort and skip asserted together in PROCESS -> same result.
REQ-032 PULSE_CNT=3, PULSE_GAP=2, FRAME_W=2 -> EXPOSE 7 cycles with shutter=1 in cycles 0, 2 and 4; after 4 completed frames frame_cnt=0.
REQ-033 Reset asserted for 1 cycle in PROCESS cycle 2 -> all outputs at reset values next cycle, no frame_done, first EXPOSE 4 cycles after release.

Source files
------------

// File: rtl/camera_sequencer_if.sv
// Control and status bundle between a camera sequencer and its controller.
interface camera_sequencer_if #(
  parameter int FRAME_W = 8
);
  logic               enable;
  logic               skip;
  logic               abort;
  logic               shutter;
  logic [1:0]         state;
  logic               frame_done;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output enable, skip, abort,
    input  shutter, state, frame_done, frame_cnt
  );

  modport slave (
    input  enable, skip, abort,
    output shutter, state, frame_done, frame_cnt
  );
endinterface

// File: rtl/camera_sequencer.sv
// Frame sequencer: idle dwell, timed shutter pulses, processing window,
// with abort/skip overrides and a wrapping completed-frame counter.
//
// state     | meaning
// S_IDLE    | dwell before the next frame, counts only while enable=1
// S_EXPOSE  | shutter pulse train, fixed PULSE_CNT*PULSE_GAP+1 cycles
// S_PROCESS | processing window, ends on terminal count or skip
module camera_sequencer #(
  parameter int IDLE_CYC  = 4,
  parameter int PULSE_CNT = 2,
  parameter int PULSE_GAP = 3,
  parameter int PROC_CYC  = 5,
  parameter int CNT_W     = 4,
  parameter int FRAME_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  camera_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_EXPOSE  = 2'b01,
    S_PROCESS = 2'b10
  } state_e;

  localparam int              EXP_CYC = PULSE_CNT * PULSE_GAP + 1;
  localparam int              PULSE_SPAN = PULSE_CNT * PULSE_GAP;
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] EXP_LD  = CNT_W'(EXP_CYC - 1);
  localparam logic [CNT_W-1:0] PROC_LD = CNT_W'(PROC_CYC - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               shutter_q, shutter_d;
  logic               frame_done_q, frame_done_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   exp_idx_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = IDLE_LD;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.enable) begin
            if (cnt_q == '0) begin
              state_d = S_EXPOSE;
              cnt_d   = EXP_LD;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        S_EXPOSE: begin
          if (cnt_q == '0) begin
            state_d = S_PROCESS;
            cnt_d   = PROC_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_PROCESS: begin
          if (bus.skip || (cnt_q == '0)) begin
            state_d      = S_IDLE;
            cnt_d        = IDLE_LD;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + FRAME_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = IDLE_LD;
        end
      endcase
    end

    // Shutter is decoded from the next-cycle exposure index so it can be registered.
    exp_idx_d = EXP_LD - cnt_d;
    shutter_d = (state_d == S_EXPOSE)
             && ((int'(exp_idx_d) % PULSE_GAP) == 0)
             && (int'(exp_idx_d) < PULSE_SPAN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= IDLE_LD;
      shutter_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shutter_q    <= shutter_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.shutter    = shutter_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_camera_sequencer.sv
// Directed bench for camera_sequencer: default timing plus a 3-pulse,
// 2-bit frame counter variant running alongside.
module tb_camera_sequencer;

  logic clk;
  logic reset;
  int   vec;
  int   errs;

  camera_sequencer_if #(.FRAME_W(8)) sif ();
  camera_sequencer_if #(.FRAME_W(2)) sif2 ();

  camera_sequencer u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  camera_sequencer #(
    .PULSE_CNT (3),
    .PULSE_GAP (2),
    .FRAME_W   (2)
  ) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (sif2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench in cycle t=0: first IDLE cycle with enable=1.
  task automatic do_reset();
    reset      = 1'b1;
    sif.enable = 1'b0;
    sif.skip   = 1'b0;
    sif.abort  = 1'b0;
    tick(1);
    reset      = 1'b0;
    sif.enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sif.enable = 1'b1;
    sif.skip = 1'b0;
    sif.abort = 1'b0;
    tick(2);
    vec++; if (sif.state !== 2'b00) begin errs++; $display("FAIL rst_state got %0d want 0", sif.state); end
    vec++; if (sif.shutter !== 1'b0) begin errs++; $display("FAIL rst_shutter got %0d want 0", sif.shutter); end
    vec++; if (sif.frame_done !== 1'b0) begin errs++; $display("FAIL rst_done got %0d want 0", sif.frame_done); end
    vec++; if (sif.frame_cnt !== 8'd0) begin errs++; $display("FAIL rst_fcnt got %0d want 0", sif.frame_cnt); end
    reset = 1'b0;
    tick(4);
    vec++; if (sif.shutter !== 1'b1) begin errs++; $display("FAIL rst_exp_sh got %0d want 1", sif.shutter); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    vec++; if (sif.state !== 2'b00) begin errs++; $display("FAIL rstexp_state got %0d want 0", sif.state); end
    vec++; if (sif.shutter !== 1'b0) begin errs++; $display("FAIL rstexp_shutter got %0d want 0", sif.shutter); end
    tick(3);
    vec++; if (sif.state !== 2'b00) begin errs++; $display("FAIL rstexp_idle3 got %0d want 0", sif.state); end
    tick(1);
    vec++; if (sif.state !== 2'b01) begin errs++; $display("FAIL rstexp_exp got %0d want 1", sif.state); end
    vec++; if (sif.shutter !== 1'b1) begin errs++; $display("FAIL rstexp_sh got %0d want 1", sif.shutter); end
  endtask

  task automatic test_frame();
    do_reset();
    for (int t = 0; t < 34; t++) begin
      int         ph;
      logic [1:0] e_st;
      logic       e_sh;
      logic       e_dn;
      logic [7:0] e_fc;
      ph   = t % 16;
      e_st = (ph < 4) ? 2'b00 : (ph < 11) ? 2'b01 : 2'b10;
      e_sh = (ph == 4) || (ph == 7);
      e_dn = (t == 16) || (t == 32);
      e_fc = 8'(t / 16);
      vec++; if (sif.state !== e_st) begin errs++; $display("FAIL frame_state t=%0d got %0d want %0d", t, sif.state, e_st); end
      vec++; if (sif.shutter !== e_sh) begin errs++; $display("FAIL frame_shutter t=%0d got %0d want %0d", t, sif.shutter, e_sh); end
      vec++; if (sif.frame_done !== e_dn) begin errs++; $display("FAIL frame_done t=%0d got %0d want %0d", t, sif.frame_done, e_dn); end
      vec++; if (sif.frame_cnt !== e_fc) begin errs++; $display("FAIL frame_cnt t=%0d got %0d want %0d", t, sif.frame_cnt, e_fc); end
      tick(1);
    end
  endtask

  task automatic test_skip();
    do_reset();
    tick(12);
    vec++; if (sif.state !== 2'b10) begin errs++; $display("FAIL skip_pre got %0d want 2", sif.state); end
    sif.skip = 1'b1;
    tick(1);
    sif.skip = 1'b0;
    vec++; if (sif.state !== 2'b00) begin errs++; $display("FAIL skip_state got %0d want 0", sif.state); end
    vec++; if (sif.frame_done !== 1'b1) begin errs++; $display("FAIL skip_done got %0d want 1", sif.frame_done); end
    vec++; if (sif.frame_cnt !== 8'd1) begin errs++; $display("FAIL skip_fcnt got %0d want 1", sif.frame_cnt); end
    tick(1);
    vec++; if (sif.frame_done !== 1'b0) begin errs++; $display("FAIL skip_done_off got %0d want 0", sif.frame_done); end
    sif.skip = 1'b1;
    tick(1);
    sif.skip = 1'b0;
    tick(1);
    vec++; if (sif.state !== 2'b00) begin errs++; $display("FAIL skip_idle_end got %0d want 0", sif.state); end
    tick(1);
    vec++; if (sif.state !== 2'b01) begin errs++; $display("FAIL skip_next_exp got %0d want 1", sif.state); end
    vec++; if (sif.shutter !== 1'b1) begin errs++; $display("FAIL skip_next_sh got %0d want 1", sif.shutter); end
  endtask

  task automatic test_enable();
    do_reset();
    tick(1);
    sif.enable = 1'b0;
    tick(3);
    vec++; if (sif.state !== 2'b00) begin errs++; $display("FAIL en_hold got %0d want 0", sif.state); end
    sif.enable = 1'b1;
    tick(2);
    vec++; if (sif.state !== 2'b00) begin errs++; $display("FAIL en_idle6 got %0d want 0", sif.state); end
    tick(1);
    vec++; if (sif.state !== 2'b01) begin errs++; $display("FAIL en_exp got %0d want 1", sif.state); end
    vec++; if (sif.shutter !== 1'b1) begin errs++; $display("FAIL en_exp_sh0 got %0d want 1", sif.shutter); end
    sif.enable = 1'b0;
    tick(3);
    vec++; if (sif.shutter !== 1'b1) begin errs++; $display("FAIL en_exp_sh3 got %0d want 1", sif.shutter); end
    tick(4);
    vec++; if (sif.state !== 2'b10) begin errs++; $display("FAIL en_proc got %0d want 2", sif.state); end
    tick(4);
    vec++; if (sif.state !== 2'b10) begin errs++; $display("FAIL en_proc_last got %0d want 2", sif.state); end
    sif.enable = 1'b1;
    tick(1);
    vec++; if (sif.state !== 2'b00) begin errs++; $display("FAIL en_done_state got %0d want 0", sif.state); end
    vec++; if (sif.frame_done !== 1'b1) begin errs++; $display("FAIL en_done got %0d want 1", sif.frame_done); end
    vec++; if (sif.frame_cnt !== 8'd1) begin errs++; $display("FAIL en_fcnt got %0d want 1", sif.frame_cnt); end
  endtask

  task automatic test_abort();
    do_reset();
    tick(4);
    vec++; if (sif.shutter !== 1'b1) begin errs++; $display("FAIL ab_pre_sh got %0d want 1", sif.shutter); end
    sif.abort = 1'b1;
    tick(1);
    sif.abort = 1'b0;
    vec++; if (sif.state !== 2'b00) begin errs++; $display("FAIL ab_state got %0d want 0", sif.state); end
    vec++; if (sif.shutter !== 1'b0) begin errs++; $display("FAIL ab_shutter got %0d want 0", sif.shutter); end
    vec++; if (sif.frame_done !== 1'b0) begin errs++; $display("FAIL ab_done got %0d want 0", sif.frame_done); end
    vec++; if (sif.frame_cnt !== 8'd0) begin errs++; $display("FAIL ab_fcnt got %0d want 0", sif.frame_cnt); end
    tick(3);
    vec++; if (sif.state !== 2'b00) begin errs++; $display("FAIL ab_reload got %0d want 0", sif.state); end
    tick(1);
    vec++; if (sif.state !== 2'b01) begin errs++; $display("FAIL ab_exp got %0d want 1", sif.state); end
    tick(8);
    vec++; if (sif.state !== 2'b10) begin errs++; $display("FAIL abs_pre got %0d want 2", sif.state); end
    sif.abort = 1'b1;
    sif.skip  = 1'b1;
    tick(1);
    sif.abort = 1'b0;
    sif.skip  = 1'b0;
    vec++; if (sif.state !== 2'b00) begin errs++; $display("FAIL abs_state got %0d want 0", sif.state); end
    vec++; if (sif.frame_done !== 1'b0) begin errs++; $display("FAIL abs_done got %0d want 0", sif.frame_done); end
    vec++; if (sif.frame_cnt !== 8'd0) begin errs++; $display("FAIL abs_fcnt got %0d want 0", sif.frame_cnt); end
    tick(3);
    vec++; if (sif.state !== 2'b00) begin errs++; $display("FAIL abs_idle got %0d want 0", sif.state); end
    tick(1);
    vec++; if (sif.state !== 2'b01) begin errs++; $display("FAIL abs_exp got %0d want 1", sif.state); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(29);
    vec++; if (sif.frame_cnt !== 8'd1) begin errs++; $display("FAIL rm_pre_fcnt got %0d want 1", sif.frame_cnt); end
    vec++; if (sif.state !== 2'b10) begin errs++; $display("FAIL rm_pre_state got %0d want 2", sif.state); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    vec++; if (sif.state !== 2'b00) begin errs++; $display("FAIL rm_state got %0d want 0", sif.state); end
    vec++; if (sif.frame_done !== 1'b0) begin errs++; $display("FAIL rm_done got %0d want 0", sif.frame_done); end
    vec++; if (sif.frame_cnt !== 8'd0) begin errs++; $display("FAIL rm_fcnt got %0d want 0", sif.frame_cnt); end
    vec++; if (sif.shutter !== 1'b0) begin errs++; $display("FAIL rm_shutter got %0d want 0", sif.shutter); end
    tick(3);
    vec++; if (sif.state !== 2'b00) begin errs++; $display("FAIL rm_idle got %0d want 0", sif.state); end
    tick(1);
    vec++; if (sif.state !== 2'b01) begin errs++; $display("FAIL rm_exp got %0d want 1", sif.state); end
  endtask

  task automatic test_param();
    do_reset();
    for (int t = 0; t <= 64; t++) begin
      if (t <= 11) begin
        logic [1:0] e_st;
        logic       e_sh;
        e_st = (t < 4) ? 2'b00 : (t < 11) ? 2'b01 : 2'b10;
        e_sh = (t == 4) || (t == 6) || (t == 8);
        vec++; if (sif2.state !== e_st) begin errs++; $display("FAIL p_state t=%0d got %0d want %0d", t, sif2.state, e_st); end
        vec++; if (sif2.shutter !== e_sh) begin errs++; $display("FAIL p_shutter t=%0d got %0d want %0d", t, sif2.shutter, e_sh); end
      end
      if (t == 16) begin
        vec++; if (sif2.frame_cnt !== 2'd1) begin errs++; $display("FAIL p_fcnt1 got %0d want 1", sif2.frame_cnt); end
      end
      if (t == 48) begin
        vec++; if (sif2.frame_cnt !== 2'd3) begin errs++; $display("FAIL p_fcnt3 got %0d want 3", sif2.frame_cnt); end
      end
      if (t == 64) begin
        vec++; if (sif2.frame_cnt !== 2'd0) begin errs++; $display("FAIL p_fcnt_wrap got %0d want 0", sif2.frame_cnt); end
        vec++; if (sif2.frame_done !== 1'b1) begin errs++; $display("FAIL p_done4 got %0d want 1", sif2.frame_done); end
      end
      tick(1);
    end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    reset = 1'b1;
    sif2.enable = 1'b1;
    sif2.skip   = 1'b0;
    sif2.abort  = 1'b0;
    test_reset();
    test_frame();
    test_skip();
    test_enable();
    test_abort();
    test_reset_mid();
    test_param();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
